// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and helpers for the 4x4 keypad scanner: FSM
//             state encoding, matrix geometry and snapshot decoders.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   // Returns {valid, code} of the lowest-index set bit.
   function automatic logic [4:0] encode_lowest(input logic [15:0] v);
      logic [4:0] res;
      res = 5'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) res = {1'b1, 4'(i)};
      end
      return res;
   endfunction

   // True when more than one bit of the snapshot is set.
   function automatic logic popcount_gt1(input logic [15:0] v);
      return (v & (v - 16'd1)) != 16'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_sync
//  Purpose  : Parameterised-width two-flop synchroniser for the raw row
//             sense lines, cleared by the synchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two back-to-back flops give metastability time to resolve.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 active-high matrix keypad, debounces over whole
//             scans and emits one KEY_PRESS pulse per accepted press.
//  Options  : KEYPAD_MULTI_REJECT_EN - snapshots with more than one key
//             down decode as "no key".
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic [3:0] COL,
   input  logic [3:0] ROW,
   output logic [3:0] ITEM_CODE,
   output logic       KEY_PRESS,
   output logic       KEY_HELD
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0]          row_sync;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [1:0]          col_q, col_d;
   logic [NUM_KEYS-1:0] snap_q, snap_d;
   state_t              state_q, state_d;
   logic [3:0]          cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          item_q, item_d;
   logic                press_q, press_d;

   logic                w_last;
   logic                w_scan_end;
   logic [4:0]          w_enc;
   logic                w_key_valid;
   logic [3:0]          w_key;
   logic [CNT_W-1:0]    w_cnt_inc;

   keypad_sync #(.WIDTH(NUM_ROWS)) u_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .d_i   (ROW),
      .q_o   (row_sync)
   );

   assign w_last     = (div_q == DIV_LAST);
   assign w_scan_end = w_last && (col_q == 2'd3);
   assign w_cnt_inc  = cnt_q + 1'b1;

   // Column dwell counter, column index and snapshot capture on the last dwell cycle.
   // snap_d already holds the column being sampled, so the decoder sees a full scan.
   always_comb begin
      div_d  = w_last ? '0 : div_q + 1'b1;
      col_d  = w_last ? col_q + 2'd1 : col_q;
      snap_d = snap_q;
      if (w_last) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            snap_d[{2'(r), col_q}] = row_sync[r];
         end
      end
   end

   assign w_enc = encode_lowest(snap_d);
   assign w_key = w_enc[3:0];
`ifdef KEYPAD_MULTI_REJECT_EN
   assign w_key_valid = w_enc[4] && !popcount_gt1(snap_d);
`else
   assign w_key_valid = w_enc[4];
`endif

   // Debounce FSM: advances only on scan-end, holds otherwise.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      item_d  = item_q;
      press_d = 1'b0;
      if (w_scan_end) begin
         case (state_q)
            IDLE: begin
               if (w_key_valid) begin
                  cand_d = w_key;
                  cnt_d  = CNT_ONE;
                  if (DEBOUNCE_SCANS == 1) begin
                     item_d  = w_key;
                     press_d = 1'b1;
                     state_d = PRESSED;
                  end else begin
                     state_d = DB_PRESS;
                  end
               end
            end
            DB_PRESS: begin
               if (w_key_valid && (w_key == cand_q)) begin
                  cnt_d = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) begin
                     item_d  = cand_q;
                     press_d = 1'b1;
                     state_d = PRESSED;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            PRESSED: begin
               if (!snap_d[cand_q]) begin
                  cnt_d   = CNT_ONE;
                  state_d = (DEBOUNCE_SCANS == 1) ? IDLE : DB_RELEASE;
               end
            end
            DB_RELEASE: begin
               if (!snap_d[cand_q]) begin
                  cnt_d = w_cnt_inc;
                  if (w_cnt_inc == CNT_DONE) state_d = IDLE;
               end else begin
                  state_d = PRESSED;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_q   <= '0;
         col_q   <= 2'd0;
         snap_q  <= '0;
         state_q <= IDLE;
         cand_q  <= 4'd0;
         cnt_q   <= '0;
         item_q  <= 4'd0;
         press_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         col_q   <= col_d;
         snap_q  <= snap_d;
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         item_q  <= item_d;
         press_q <= press_d;
      end
   end

   assign COL       = 4'b0001 << col_q;
   assign ITEM_CODE = item_q;
   assign KEY_PRESS = press_q;
   assign KEY_HELD  = (state_q == PRESSED) || (state_q == DB_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner with a behavioural
//             key matrix and a KEY_PRESS scoreboard.
//  Options  : KEYPAD_MULTI_REJECT_EN changes the expectation for two keys.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

   logic        CLK   = 1'b0;
   logic        RESET = 1'b1;
   logic [3:0]  COL;
   logic [3:0]  ROW;
   logic [3:0]  ITEM_CODE;
   logic        KEY_PRESS;
   logic        KEY_HELD;

   logic [15:0] pressed_keys = 16'd0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          press_cnt = 0;
   int          exp_total = 0;
   int          last_press_cyc = -1;
   int          prev_press_cyc = -1;
   logic [3:0]  exp_q[$];

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .COL       (COL),
      .ROW       (ROW),
      .ITEM_CODE (ITEM_CODE),
      .KEY_PRESS (KEY_PRESS),
      .KEY_HELD  (KEY_HELD)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Matrix model: a row reads high when a pressed key sits on a driven column.
   for (genvar r = 0; r < 4; r++) begin : g_row
      assign ROW[r] = |(COL & pressed_keys[r*4 +: 4]);
   end

   // Monitor: every KEY_PRESS pulse consumes one expected code.
   always @(negedge CLK) begin
      if (KEY_PRESS === 1'b1) begin
         press_cnt++;
         prev_press_cyc = last_press_cyc;
         last_press_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_press: ITEM_CODE=%0d, required no pulse", ITEM_CODE);
         end else begin
            automatic logic [3:0] exp = exp_q.pop_front();
            if (ITEM_CODE !== exp) begin
               errors++;
               $display("FAIL press_code: got %0d, required %0d", ITEM_CODE, exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic expect_press(input logic [3:0] code);
      exp_q.push_back(code);
      exp_total++;
   endtask

   // Align to the first cycle of column 0.
   task automatic wait_scan_start();
      int n;
      n = 0;
      while (COL !== 4'b1000 && n < 20) begin tick(1); n++; end
      n = 0;
      while (COL !== 4'b0001 && n < 20) begin tick(1); n++; end
      chk("scan_align", COL, 4'b0001);
   endtask

   task automatic wait_held(input logic val, input int max, input string name);
      int n;
      n = 0;
      while (KEY_HELD !== val && n < max) begin tick(1); n++; end
      chk(name, KEY_HELD, val);
   endtask

   task automatic wait_press(input int base, input int max, input string name);
      int n;
      n = 0;
      while (press_cnt <= base && n < max) begin tick(1); n++; end
      chk(name, press_cnt, base + 1);
   endtask

   initial begin
      int t0;
      int base;

      // 1: reset values and column scan timing
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_col", COL, 4'b0001);
      chk("rst_item", ITEM_CODE, 4'd0);
      chk("rst_press", KEY_PRESS, 1'b0);
      chk("rst_held", KEY_HELD, 1'b0);
      RESET = 1'b0;
      tick(3);  chk("col_c3", COL, 4'b0001);
      tick(1);  chk("col_c4", COL, 4'b0010);
      tick(11); chk("col_c15", COL, 4'b1000);
      tick(1);  chk("col_c16", COL, 4'b0001);

      // 2: key r1c2 held, latency, no repeat, release
      wait_scan_start();
      t0 = cyc;
      base = press_cnt;
      expect_press(4'd6);
      pressed_keys[6] = 1'b1;
      wait_press(base, 60, "k6_pressed");
      chk_range("k6_latency", last_press_cyc - t0, 40, 49);
      chk("k6_held", KEY_HELD, 1'b1);
      tick(150);
      chk("k6_single_pulse", press_cnt, base + 1);
      chk("k6_item_hold", ITEM_CODE, 4'd6);
      pressed_keys[6] = 1'b0;
      tick(20);
      chk("k6_held_debounce", KEY_HELD, 1'b1);
      wait_held(1'b0, 80, "k6_released");
      chk("k6_item_after_rel", ITEM_CODE, 4'd6);

      // 3: short bounce on r0c3 is rejected
      base = press_cnt;
      pressed_keys[3] = 1'b1;
      tick(10);
      pressed_keys[3] = 1'b0;
      tick(80);
      chk("bounce_no_press", press_cnt, base);
      chk("bounce_item", ITEM_CODE, 4'd6);
      chk("bounce_held", KEY_HELD, 1'b0);

      // 4: key 0 then key 5, pulses at least three scans apart
      base = press_cnt;
      expect_press(4'd0);
      pressed_keys[0] = 1'b1;
      wait_press(base, 80, "k0_pressed");
      tick(60);
      pressed_keys[0] = 1'b0;
      wait_held(1'b0, 80, "k0_released");
      base = press_cnt;
      expect_press(4'd5);
      pressed_keys[5] = 1'b1;
      wait_press(base, 80, "k5_pressed");
      chk_range("k0_k5_spacing", last_press_cyc - prev_press_cyc, 48, 100000);
      chk("k5_item", ITEM_CODE, 4'd5);
      tick(60);
      pressed_keys[5] = 1'b0;
      wait_held(1'b0, 80, "k5_released");

      // 5: keys 3 and 9 together
      base = press_cnt;
`ifdef KEYPAD_MULTI_REJECT_EN
      pressed_keys[3] = 1'b1;
      pressed_keys[9] = 1'b1;
      tick(100);
      chk("multi_no_press", press_cnt, base);
      chk("multi_held", KEY_HELD, 1'b0);
      chk("multi_item", ITEM_CODE, 4'd5);
`else
      expect_press(4'd3);
      pressed_keys[3] = 1'b1;
      pressed_keys[9] = 1'b1;
      tick(100);
      chk("multi_one_press", press_cnt, base + 1);
      chk("multi_held", KEY_HELD, 1'b1);
      chk("multi_item", ITEM_CODE, 4'd3);
`endif
      pressed_keys[3] = 1'b0;
      pressed_keys[9] = 1'b0;
      wait_held(1'b0, 80, "multi_released");

      // 6: reset while key 6 is held, then re-acceptance
      base = press_cnt;
      expect_press(4'd6);
      pressed_keys[6] = 1'b1;
      wait_held(1'b1, 100, "k6b_held");
      tick(10);
      RESET = 1'b1;
      tick(1);
      chk("mid_rst_held", KEY_HELD, 1'b0);
      chk("mid_rst_item", ITEM_CODE, 4'd0);
      chk("mid_rst_col", COL, 4'b0001);
      RESET = 1'b0;
      t0 = cyc;
      base = press_cnt;
      expect_press(4'd6);
      wait_press(base, 100, "k6_repress");
      chk_range("k6_repress_latency", last_press_cyc - t0, 40, 52);
      chk("k6_repress_item", ITEM_CODE, 4'd6);
      chk("k6_repress_held", KEY_HELD, 1'b1);
      pressed_keys[6] = 1'b0;
      wait_held(1'b0, 80, "k6_repress_released");
      tick(5);

      chk("scoreboard_drained", exp_q.size(), 0);
      chk("press_total", press_cnt, exp_total);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
